// File: rtl/accumulator_scheduler_if.sv
// Request/grant bundle between the requesting datapaths and the shared accumulator scheduler.
// The master side drives requests and samples; the slave side (the scheduler) returns grant and result.
interface accumulator_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int CNTW  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNTW-1:0]  len;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       dvld;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  ovf;
  logic [NREQ-1:0]       done;

  modport master (output req, len, din, dvld, input gnt, q, ovf, done);
  modport slave  (input req, len, din, dvld, output gnt, q, ovf, done);
endinterface

// File: rtl/accumulator_scheduler.sv
// Round-robin owner of one unsigned accumulator: grants a requester, sums its burst, reports sum + done pulse.
// Define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module accumulator_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int CNTW  = 4
) (
  input logic                    c,
  input logic                    clr_n,
  accumulator_scheduler_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ACCUM, FIN} state_t;

  state_t           state;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  g;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] acc;
  logic             acc_ovf;

  logic [IDXW-1:0]  cand;
  logic [IDXW-1:0]  sel;
  logic             found;
  logic [NREQ-1:0]  sel_hot;
  logic [NREQ-1:0]  g_hot;
  logic [CNTW-1:0]  len_sel;
  logic [WIDTH-1:0] din_g;
  logic             dvld_g;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;

  // Search starts one past the last owner so the requester that just finished ranks lowest.
  always_comb begin
    cand  = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((int'(ptr) + k + 1) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_hot = {{(NREQ-1){1'b0}}, 1'b1} << sel;
    g_hot   = {{(NREQ-1){1'b0}}, 1'b1} << g;
    len_sel = bus.len[sel*CNTW +: CNTW];
    din_g   = bus.din[g*WIDTH +: WIDTH];
    dvld_g  = bus.dvld[g];
    sum     = {1'b0, acc} + {1'b0, din_g};
    ovf_nxt = acc_ovf | sum[WIDTH];
`ifdef ACC_SAT_EN
    acc_nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    acc_nxt = sum[WIDTH-1:0];
`endif
  end

  // A zero-length burst skips ACCUM and reports a zero result directly.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      ptr      <= IDXW'(NREQ - 1);
      g        <= '0;
      cnt      <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      bus.gnt  <= '0;
      bus.done <= '0;
      bus.q    <= '0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g       <= sel;
            cnt     <= len_sel;
            acc     <= '0;
            acc_ovf <= 1'b0;
            if (len_sel != '0) begin
              bus.gnt <= sel_hot;
              state   <= ACCUM;
            end else begin
              bus.q    <= '0;
              bus.ovf  <= 1'b0;
              bus.done <= sel_hot;
              state    <= FIN;
            end
          end
        end
        ACCUM: begin
          if (dvld_g) begin
            acc     <= acc_nxt;
            acc_ovf <= ovf_nxt;
            cnt     <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
              bus.q    <= acc_nxt;
              bus.ovf  <= ovf_nxt;
              bus.gnt  <= '0;
              bus.done <= g_hot;
              state    <= FIN;
            end
          end
        end
        FIN: begin
          ptr      <= g;
          bus.done <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_scheduler.sv
// Directed bench for accumulator_scheduler: a burst-level model checked every cycle plus literal spot checks.
// Build with ACC_SAT_EN defined to check the saturating variant.
module tb_accumulator_scheduler;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int CNTW  = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic c = 1'b0;
  logic clr_n = 1'b0;
  int checks = 0;
  int errors = 0;

  accumulator_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) bus();

  accumulator_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .c     (c),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 c = ~c;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Burst-level model: tracks owner, samples still owed and the true integer total.
  int owner = -1;
  int remaining = 0;
  int total = 0;
  int lastOwner = NREQ - 1;
  int cool = 0;
  int pick = -1;
  logic [NREQ-1:0]  expGnt = '0;
  logic [NREQ-1:0]  expDone = '0;
  logic [WIDTH-1:0] expQ = '0;
  logic             expOvf = 1'b0;

  function automatic int resultOf(input int t);
`ifdef ACC_SAT_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 1);
`endif
  endfunction

  always @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      owner = -1; remaining = 0; total = 0; lastOwner = NREQ - 1; cool = 0;
      expGnt = '0; expDone = '0; expQ = '0; expOvf = 1'b0;
    end else begin
      expDone = '0;
      if (owner >= 0) begin
        if (bus.dvld[owner]) begin
          total += int'(bus.din[owner*WIDTH +: WIDTH]);
          remaining--;
          if (remaining == 0) begin
            expQ = WIDTH'(resultOf(total));
            expOvf = (total > MAXV);
            expDone[owner] = 1'b1;
            expGnt = '0;
            lastOwner = owner;
            owner = -1;
            cool = 1;
          end
        end
      end else if (cool > 0) begin
        cool--;
      end else if (bus.req != '0) begin
        pick = -1;
        for (int k = 1; k <= NREQ; k++)
          if (pick < 0 && bus.req[(lastOwner + k) % NREQ]) pick = (lastOwner + k) % NREQ;
        total = 0;
        remaining = int'(bus.len[pick*CNTW +: CNTW]);
        if (remaining == 0) begin
          expQ = '0; expOvf = 1'b0; expDone[pick] = 1'b1; lastOwner = pick; cool = 1;
        end else begin
          owner = pick; expGnt = '0; expGnt[pick] = 1'b1;
        end
      end
    end
  end

  always @(negedge c) begin
    checkOutput("cyc gnt",  32'(bus.gnt),  32'(expGnt));
    checkOutput("cyc done", 32'(bus.done), 32'(expDone));
    checkOutput("cyc q",    32'(bus.q),    32'(expQ));
    checkOutput("cyc ovf",  32'(bus.ovf),  32'(expOvf));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] dvld);
    bus.req  = req;
    bus.dvld = dvld;
  endtask

  task automatic setLen(input int i, input logic [CNTW-1:0] v);
    bus.len[i*CNTW +: CNTW] = v;
  endtask

  task automatic setDin(input int i, input logic [WIDTH-1:0] v);
    bus.din[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic int oneHotIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int order[$];
  logic [NREQ-1:0] prevGnt;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] vals[4] = '{4'd5, 4'd9, 4'd9, 4'd6};

  initial begin
    bus.req = '0; bus.len = '0; bus.din = '0; bus.dvld = '0;
    tick(2);
    checkOutput("reset gnt", 32'(bus.gnt), 0);
    checkOutput("reset done", 32'(bus.done), 0);
    checkOutput("reset q", 32'(bus.q), 0);
    checkOutput("reset ovf", 32'(bus.ovf), 0);
    clr_n = 1'b1;
    tick(1);

    // Requester 1 sums 2+3+4.
    setLen(1, 4'd3);
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("s1 gnt", 32'(bus.gnt), 32'h2);
    applyStimulus(4'b0000, 4'b0010);
    setDin(1, 4'd2); tick();
    setDin(1, 4'd3); tick();
    setDin(1, 4'd4); tick();
    checkOutput("s1 done", 32'(bus.done), 32'h2);
    checkOutput("s1 q", 32'(bus.q), 9);
    checkOutput("s1 ovf", 32'(bus.ovf), 0);
    checkOutput("s1 gnt low", 32'(bus.gnt), 0);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("s1 done pulse", 32'(bus.done), 0);
    tick(2);

    // Zero-length burst from requester 3.
    setLen(3, 4'd0);
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("s5 done", 32'(bus.done), 32'h8);
    checkOutput("s5 q", 32'(bus.q), 0);
    checkOutput("s5 gnt", 32'(bus.gnt), 0);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("s5 done pulse", 32'(bus.done), 0);
    checkOutput("s5 gnt still", 32'(bus.gnt), 0);
    tick(2);

    // Requester 0 with gaps in its valid stream; requester 3 keeps offering 7.
    setLen(0, 4'd2);
    setDin(3, 4'd7);
    applyStimulus(4'b0001, 4'b1000);
    tick();
    checkOutput("s4 gnt", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      setDin(0, vals[i]);
      applyStimulus(4'b0000, {1'b1, 2'b00, pat[i]});
      tick();
    end
    checkOutput("s4 done", 32'(bus.done), 32'h1);
    checkOutput("s4 q", 32'(bus.q), 11);
    applyStimulus(4'b0000, 4'b0000);
    tick(3);

    // Requester 2 overflows: 15 + 3.
    setLen(2, 4'd2);
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("s2 gnt", 32'(bus.gnt), 32'h4);
    applyStimulus(4'b0000, 4'b0100);
    setDin(2, 4'd15); tick();
    setDin(2, 4'd3); tick();
    checkOutput("s2 done", 32'(bus.done), 32'h4);
`ifdef ACC_SAT_EN
    checkOutput("s2 q", 32'(bus.q), 15);
`else
    checkOutput("s2 q", 32'(bus.q), 2);
`endif
    checkOutput("s2 ovf", 32'(bus.ovf), 1);
    applyStimulus(4'b0000, 4'b0000);
    tick(3);

    // Mid-burst reset: requester 3 wins first, is aborted, then requester 1 is served.
    setLen(1, 4'd5); setLen(3, 4'd5);
    setDin(1, 4'd1); setDin(3, 4'd1);
    applyStimulus(4'b1010, 4'b0000);
    tick();
    checkOutput("s6 gnt before", 32'(bus.gnt), 32'h8);
    applyStimulus(4'b1010, 4'b1010);
    tick(2);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("s6 async gnt", 32'(bus.gnt), 0);
    checkOutput("s6 async done", 32'(bus.done), 0);
    checkOutput("s6 async q", 32'(bus.q), 0);
    checkOutput("s6 async ovf", 32'(bus.ovf), 0);
    @(posedge c);
    #3 clr_n = 1'b1;
    tick();
    checkOutput("s6 gnt after", 32'(bus.gnt), 32'h2);
    tick(5);
    checkOutput("s6 done", 32'(bus.done), 32'h2);
    checkOutput("s6 q", 32'(bus.q), 5);
    applyStimulus(4'b0000, 4'b0000);
    tick(3);

    // All four requesting single-sample bursts: rotation 0,1,2,3,0 from reset.
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      setLen(i, 4'd1);
      setDin(i, WIDTH'(i + 1));
    end
    applyStimulus(4'b1111, 4'b1111);
    prevGnt = '0;
    for (int cyc = 0; cyc < 20 && order.size() < 5; cyc++) begin
      tick();
      if (bus.gnt != '0 && prevGnt == '0) order.push_back(oneHotIdx(bus.gnt));
      prevGnt = bus.gnt;
    end
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("s3 grant count", 32'(order.size()), 5);
    for (int i = 0; i < order.size(); i++)
      checkOutput($sformatf("s3 grant %0d", i), 32'(order[i]), 32'(i % NREQ));
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
